// File: rtl/sample_run_packer_if.sv
// rtl/sample_run_packer_if.sv - sample input and run-record output handshake bundle
interface sample_run_packer_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_len;
    logic [15:0] out_sum;
    logic [7:0]  out_peak;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_len, out_sum, out_peak
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_len, out_sum, out_peak
    );
endinterface

// File: rtl/sample_run_packer.sv
// rtl/sample_run_packer.sv - packs runs of nonzero samples into {len,sum,peak} records behind a show-ahead FIFO
module sample_run_packer #(
    parameter int MAX_RUN    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    sample_run_packer_if.slave          bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [7:0]      MAX_LEN  = 8'(MAX_RUN);
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q, state_d;
    logic [7:0]  len_q, len_d, peak_q, peak_d;
    logic [15:0] sum_q, sum_d;
    logic [7:0]  acc_len, acc_peak, rec_len, rec_peak;
    logic [15:0] acc_sum, rec_sum;
    logic        emit;

    logic [7:0]    len_mem  [FIFO_DEPTH];
    logic [15:0]   sum_mem  [FIFO_DEPTH];
    logic [7:0]    peak_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q;
    logic          head_valid, full, pop, push;

    // Accumulators are held at zero in IDLE, so a first sample and a continuing
    // sample share the same "add this sample" arithmetic.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        sum_d    = sum_q;
        peak_d   = peak_q;
        emit     = 1'b0;
        rec_len  = len_q;
        rec_sum  = sum_q;
        rec_peak = peak_q;
        acc_len  = len_q + 8'd1;
        acc_sum  = sum_q + {8'd0, bus.in_data};
        acc_peak = (bus.in_data > peak_q) ? bus.in_data : peak_q;

        if (bus.in_valid) begin
            if (bus.in_data != 8'd0) begin
                if (acc_len == MAX_LEN) begin
                    emit     = 1'b1;
                    rec_len  = acc_len;
                    rec_sum  = acc_sum;
                    rec_peak = acc_peak;
                    state_d  = IDLE;
                    len_d    = 8'd0;
                    sum_d    = 16'd0;
                    peak_d   = 8'd0;
                end else begin
                    state_d  = RUN;
                    len_d    = acc_len;
                    sum_d    = acc_sum;
                    peak_d   = acc_peak;
                end
            end else if (state_q == RUN) begin
                // The terminating zero closes the run but is not part of it.
                emit    = 1'b1;
                state_d = IDLE;
                len_d   = 8'd0;
                sum_d   = 16'd0;
                peak_d  = 8'd0;
            end
        end
    end

    assign head_valid = (count_q != '0);
    assign full       = (count_q == FULL_CNT);
    assign pop        = head_valid & bus.out_ready;
    // A full FIFO still takes a record when the head leaves on the same edge.
    assign push       = emit & (~full | pop);
    assign count_d    = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= 8'd0;
            sum_q      <= 16'd0;
            peak_q     <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            peak_q  <= peak_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (emit & full & ~pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            len_mem[wr_ptr_q]  <= rec_len;
            sum_mem[wr_ptr_q]  <= rec_sum;
            peak_mem[wr_ptr_q] <= rec_peak;
        end
    end

    assign bus.out_valid = head_valid;
    assign bus.out_len   = head_valid ? len_mem[rd_ptr_q]  : 8'd0;
    assign bus.out_sum   = head_valid ? sum_mem[rd_ptr_q]  : 16'd0;
    assign bus.out_peak  = head_valid ? peak_mem[rd_ptr_q] : 8'd0;
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_sample_run_packer.sv
// tb/tb_sample_run_packer.sv - scoreboard bench for sample_run_packer with a queue-based run model
module tb_sample_run_packer;
    localparam int MAX_RUN = 16;
    localparam int DEPTH   = 4;

    typedef struct {
        int len;
        int sum;
        int peak;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    logic [2:0] fifo_count;
    logic overflow;

    sample_run_packer_if bus();

    sample_run_packer #(.MAX_RUN(MAX_RUN), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    rec_t sb[$];
    int   run_q[$];
    int   m_count = 0;
    bit   m_ovf   = 0;
    bit   started = 0;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic rec_t summarize();
        rec_t r;
        r.len  = run_q.size();
        r.sum  = 0;
        r.peak = 0;
        foreach (run_q[i]) begin
            r.sum += run_q[i];
            if (run_q[i] > r.peak) r.peak = run_q[i];
        end
        return r;
    endfunction

    // Reference model: advances on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        bit   pop, emit;
        rec_t r;
        if (reset) begin
            started = 1;
            sb.delete();
            run_q.delete();
            m_count = 0;
            m_ovf   = 0;
        end else if (started) begin
            pop  = (m_count != 0) && bus.out_ready;
            emit = 0;
            if (bus.in_valid) begin
                if (bus.in_data != 8'd0) begin
                    run_q.push_back(int'(bus.in_data));
                    if (run_q.size() == MAX_RUN) emit = 1;
                end else if (run_q.size() != 0) begin
                    emit = 1;
                end
            end
            if (emit) begin
                r = summarize();
                run_q.delete();
                if (m_count < DEPTH || pop) begin
                    sb.push_back(r);
                    if (!pop) m_count++;
                end else begin
                    m_ovf = 1;
                    if (pop) m_count--;
                end
            end else if (pop) begin
                m_count--;
            end
        end
    end

    // Monitor: compares the presented head with the scoreboard front.
    always @(negedge clk) begin
        if (started && !reset) begin
            chk("out_valid", int'(bus.out_valid), int'(m_count != 0));
            chk("fifo_count", int'(fifo_count), m_count);
            chk("overflow", int'(overflow), int'(m_ovf));
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_record", 1, 0);
                end else begin
                    chk("out_len", int'(bus.out_len), sb[0].len);
                    chk("out_sum", int'(bus.out_sum), sb[0].sum);
                    chk("out_peak", int'(bus.out_peak), sb[0].peak);
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end else begin
                chk("idle_len", int'(bus.out_len), 0);
                chk("idle_sum", int'(bus.out_sum), 0);
                chk("idle_peak", int'(bus.out_peak), 0);
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b1, 8'h55, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        chk("reset_count", int'(fifo_count), 0);
        chk("reset_valid", int'(bus.out_valid), 0);
        chk("reset_overflow", int'(overflow), 0);

        // Basic run closed by a zero
        step(1'b1, 8'h90, 1'b1);
        step(1'b1, 8'hA0, 1'b1);
        step(1'b1, 8'h85, 1'b1);
        chk("basic_no_early_valid", int'(bus.out_valid), 0);
        step(1'b1, 8'h00, 1'b1);
        chk("basic_valid", int'(bus.out_valid), 1);
        chk("basic_len", int'(bus.out_len), 3);
        chk("basic_sum", int'(bus.out_sum), 16'h01B5);
        chk("basic_peak", int'(bus.out_peak), 8'hA0);
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Forced emission at MAX_RUN
        do_reset();
        repeat (MAX_RUN) step(1'b1, 8'hFF, 1'b1);
        chk("maxrun_len", int'(bus.out_len), 16);
        chk("maxrun_sum", int'(bus.out_sum), 16'h0FF0);
        chk("maxrun_peak", int'(bus.out_peak), 8'hFF);
        step(1'b1, 8'hFF, 1'b1);
        step(1'b1, 8'h00, 1'b1);
        chk("maxrun_next_len", int'(bus.out_len), 1);
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Bubbles do not end a run
        do_reset();
        step(1'b1, 8'h81, 1'b0);
        repeat (3) step(1'b0, 8'h77, 1'b0);
        step(1'b1, 8'h82, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        chk("bubble_len", int'(bus.out_len), 2);
        chk("bubble_sum", int'(bus.out_sum), 16'h0103);
        chk("bubble_peak", int'(bus.out_peak), 8'h82);
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Overflow with a stalled consumer
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(8'h81 + i), 1'b0);
            step(1'b1, 8'h00, 1'b0);
        end
        chk("ovf_count", int'(fifo_count), 4);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_head", int'(bus.out_peak), 8'h81);
        repeat (6) step(1'b0, 8'h00, 1'b1);
        chk("ovf_sticky", int'(overflow), 1);

        // Emit and pop on the same edge with a full FIFO
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'h81 + i), 1'b0);
            step(1'b1, 8'h00, 1'b0);
        end
        step(1'b1, 8'h85, 1'b0);
        step(1'b1, 8'h00, 1'b1);
        chk("fullpop_count", int'(fifo_count), 4);
        chk("fullpop_overflow", int'(overflow), 0);
        chk("fullpop_head", int'(bus.out_peak), 8'h82);
        repeat (6) step(1'b0, 8'h00, 1'b1);

        // Reset mid-run discards the partial run
        do_reset();
        step(1'b1, 8'h90, 1'b1);
        step(1'b1, 8'h91, 1'b1);
        do_reset();
        chk("midreset_count", int'(fifo_count), 0);
        chk("midreset_valid", int'(bus.out_valid), 0);
        step(1'b1, 8'h88, 1'b1);
        step(1'b1, 8'h00, 1'b1);
        chk("midreset_len", int'(bus.out_len), 1);
        chk("midreset_sum", int'(bus.out_sum), 16'h0088);
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic       v, r;
            logic [7:0] d;
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 7))
                0, 1:    d = 8'h00;
                2:       d = 8'hFF;
                default: d = 8'($urandom_range(1, 255));
            endcase
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(v, d, r);
            end
        end
        repeat (DEPTH + 4) step(1'b0, 8'h00, 1'b1);
        chk("drain_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
